// File: rtl/sram_stream_reader_if.sv
// sram_stream_reader_if: SRAM read port plus output stream bundle.
// master = reader side, slave = SRAM model / stream consumer side.
interface sram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  sram_cs;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output sram_cs, sram_we, sram_addr, sram_din,
    output m_valid, m_data, m_last,
    input  sram_dout, m_ready
  );

  modport slave (
    input  sram_cs, sram_we, sram_addr, sram_din,
    input  m_valid, m_data, m_last,
    output sram_dout, m_ready
  );
endinterface

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: burst-reads SRAM into a 2-deep valid/ready stream.
// Optional SRAM_STREAM_READER_CHECKSUM_EN adds a per-burst beat checksum.
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
`ifdef SRAM_STREAM_READER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  sram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   beats;

  logic                  pend;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;

  logic                  issue;
  logic                  valid;
  logic                  xfer;
  logic                  pop;
  logic                  capture;
  logic                  last;

  // A read may issue only while buffered plus in-flight words stay below 2.
  assign issue = (state == RUN) && ((cnt + {1'b0, pend}) < 2'd2);

  // The word returning this cycle is shown directly when the FIFO is empty.
  assign valid   = (cnt != 2'd0) || pend;
  assign xfer    = valid && bus.m_ready;
  assign pop     = xfer && (cnt != 2'd0);
  assign capture = pend && !((cnt == 2'd0) && xfer);
  assign last    = (beats == len_r - ONE);

  assign bus.sram_cs   = issue;
  assign bus.sram_we   = 1'b0;
  assign bus.sram_addr = addr;
  assign bus.sram_din  = '0;
  assign bus.m_valid   = valid;
  assign bus.m_last    = valid && last;
  assign bus.m_data    = (cnt != 2'd0) ? fifo[rd_ptr] :
                         (pend ? bus.sram_dout : '0);

  // Return-data capture and 2-entry FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      pend <= issue;
      if (capture) begin
        fifo[wr_ptr] <= bus.sram_dout;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, capture} - {1'b0, pop};
    end
  end

  // Burst control: address walk, counters, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      addr   <= '0;
      len_r  <= '0;
      issued <= '0;
      beats  <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        addr   <= addr + ADDR_WIDTH'(1);
        issued <= issued + ONE;
      end
      if (xfer) beats <= beats + ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr   <= base_addr;
            len_r  <= length;
            issued <= '0;
            beats  <= '0;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (issued == len_r - ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (xfer && last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_STREAM_READER_CHECKSUM_EN
  // Running sum of transferred beats, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start && (state == IDLE)) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + bus.m_data;
    end
  end
`endif

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the SRAM word and stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the SRAM address width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle burst request.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first SRAM address, sampled with start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  word count, sampled with start; legal range 0..2**ADDR_WIDTH.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port sram_cs  output  1  SRAM chip select.
REQ-011 SHALL have port sram_we  output  1  SRAM write enable; tied 0.
REQ-012 SHALL have port sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-013 SHALL have port sram_din  output  DATA_WIDTH  SRAM write data; tied 0.
REQ-014 SHALL have port sram_dout  input  DATA_WIDTH  SRAM read data, valid one cycle after the cs=1/we=0 edge.
REQ-015 SHALL have port m_valid  output  1  stream beat valid.
REQ-016 SHALL have port m_ready  input  1  stream consumer ready.
REQ-017 SHALL have port m_data  output  DATA_WIDTH  stream beat data.
REQ-018 SHALL have port m_last  output  1  high on the final beat of a burst.

Function
REQ-019 SHALL implement FSM IDLE -> RUN (issue reads) -> DRAIN (all issued; empty buffer) -> IDLE.
REQ-020 SHALL accept start only in IDLE; start while busy is ignored with no state change.
REQ-021 SHALL, on start with length=0, issue no reads, emit no beats, pulse done the next cycle, and keep busy low.
REQ-022 SHALL issue one read per cycle (sram_cs=1, sram_addr=current) in RUN only when buffered words plus in-flight reads < 2.
REQ-023 SHALL increment the address modulo 2**ADDR_WIDTH after each issued read (base 0xF -> 0x0 wraps).
REQ-024 SHALL capture sram_dout into a 2-entry FIFO exactly one cycle after each issued read.
REQ-025 SHALL present FIFO head as m_data with m_valid=1 whenever FIFO non-empty; a beat transfers when m_valid&m_ready.
REQ-026 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-027 SHALL allow a simultaneous capture and transfer in the same cycle without loss or duplication.
REQ-028 SHALL assert m_last only on the beat whose index equals length-1.
REQ-029 SHALL move RUN -> DRAIN after the length-th read issues, and DRAIN -> IDLE on transfer of the m_last beat, pulsing done in the first IDLE cycle.
REQ-030 SHALL sustain one beat per cycle when m_ready is held 1 (first beat 2 cycles after start, beat N at cycle N+1).
REQ-031 SHALL drive sram_cs=0 in IDLE and DRAIN and on every cycle no read is issued.

Reset
REQ-032 SHALL, on rst_n=0, immediately clear: FSM=IDLE, busy=0, done=0, sram_cs=0, sram_addr=0, m_valid=0, m_last=0, m_data=0, FIFO empty, counters 0.
REQ-033 SHALL abandon any burst in progress on reset, with no done pulse and no further beats.
REQ-034 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-035 SHALL, with macro SRAM_STREAM_READER_CHECKSUM_EN defined, add output checksum [DATA_WIDTH] = modular sum of all transferred beats of the burst, valid while done=1, cleared to 0 on start and reset.
REQ-036 SHALL, without SRAM_STREAM_READER_CHECKSUM_EN, omit the checksum port and logic entirely.

Verification
REQ-037 SHALL cover: SRAM preloaded mem[i]=i*0x11, start base=0 length=16, m_ready=1 -> beats 0x00..0xFF in order, m_last on 16th, done 1 cycle after it, 17 consecutive busy cycles.
REQ-038 SHALL cover: base=0xE length=4 -> sram_addr sequence 0xE,0xF,0x0,0x1; data mem[14],mem[15],mem[0],mem[1].
REQ-039 SHALL cover: length=6, m_ready toggling 1,0,0,1 repeating -> 6 beats in order, no drop/duplicate, m_data stable while stalled, at most 2 outstanding words.
REQ-040 SHALL cover: length=0 -> no sram_cs, no m_valid, done pulse next cycle, busy stays 0.
REQ-041 SHALL cover: rst_n low after 3rd beat of length=8 burst -> all outputs 0 same cycle; subsequent length=2 burst completes correctly.
REQ-042 SHALL cover, with SRAM_STREAM_READER_CHECKSUM_EN: mem = 0x80,0x90,0x10 length=3 -> checksum 0x20 during done.
